// File: rtl/ahb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module  : ahb_mem_slave
// Brief   : AHB-Lite slave front end for a synchronous single-port memory macro
// Rev     : 1.0  initial release
// ============================================================================
module ahb_mem_slave #(
  parameter int          DATA_BITS     = 32,
  parameter int          MEM_ADDR_BITS = 14,
  parameter int          RD_LATENCY    = 1,
  parameter bit          WRITE_EN      = 1'b1,
  parameter logic [15:0] MASTER_MASK   = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                HADDR,
  input  logic [2:0]                 HSIZE,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [DATA_BITS-1:0]       HWDATA,
  input  logic [3:0]                 HMASTER,
  input  logic                       HMASTLOCK,
  input  logic                       HSEL_S,
  input  logic                       HREADY,
  output logic [DATA_BITS-1:0]       HRDATA_S,
  output logic                       HREADY_S,
  output logic [1:0]                 HRESP_S,
  output logic                       mem_enable,
  output logic [MEM_ADDR_BITS-1:0]   mem_address,
  output logic [DATA_BITS-1:0]       mem_wdata,
  output logic [DATA_BITS/8-1:0]     mem_web,
  input  logic [DATA_BITS-1:0]       mem_rdata
);

  localparam int BYTES = DATA_BITS / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int AW    = MEM_ADDR_BITS + OFF;
  localparam int CW    = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            w_rd_done;
  logic            w_ready;
  logic            w_accept;
  logic            w_size_bad;
  logic            w_misalign;
  logic            w_err;
  logic [BYTES-1:0] w_lanes;
  logic            w_unused;

  assign w_unused  = ^{HMASTLOCK, HTRANS[0], HADDR[31:AW]};

  assign w_rd_done = (state_q == S_RD) && (cnt_q == CW'(RD_LATENCY));
  // Slave is ready in every state except the ERROR first cycle and read waits.
  assign w_ready   = (state_q != S_ERR1) && !((state_q == S_RD) && !w_rd_done);
  assign w_accept  = w_ready && HSEL_S && HREADY && HTRANS[1];

  always_comb begin
    w_size_bad = (HSIZE > 3'(OFF));
    w_misalign = 1'b0;
    for (int i = 0; i < OFF; i++) begin
      if ((i < int'(HSIZE)) && HADDR[i]) w_misalign = 1'b1;
    end
    w_err = !MASTER_MASK[HMASTER] || w_size_bad || w_misalign || (HWRITE && !WRITE_EN);
  end

  // Little-endian lanes: 2**size bytes starting at the captured byte offset.
  always_comb begin
    w_lanes = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_lanes[i] = (i >= int'(addr_q[OFF-1:0])) &&
                   (i < int'(addr_q[OFF-1:0]) + (1 << size_q));
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RD:    if (!w_rd_done) cnt_d = cnt_q + 1'b1;
      S_ERR1:  state_d = S_ERR2;
      default: ;
    endcase
    if (w_ready) begin
      cnt_d = '0;
      if (w_accept) begin
        addr_d  = HADDR[AW-1:0];
        size_d  = HSIZE;
        state_d = w_err ? S_ERR1 : (HWRITE ? S_WR : S_RD);
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
    end
  end

  assign HREADY_S    = w_ready;
  assign HRESP_S     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
  assign HRDATA_S    = w_rd_done ? mem_rdata : '0;
  assign mem_enable  = (state_q == S_WR) || ((state_q == S_RD) && (cnt_q == '0));
  assign mem_address = mem_enable ? addr_q[AW-1:OFF] : '0;
  assign mem_wdata   = (state_q == S_WR) ? HWDATA : '0;
  assign mem_web     = (state_q == S_WR) ? w_lanes : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_slave.sv
`default_nettype none
// Bench for ahb_mem_slave: two instances (default latency, and latency 3 /
// read-only / restricted masters) driven against a byte-level reference memory.
`timescale 1ns/1ps
module tb_ahb_mem_slave;

  logic        clk;
  logic        rst;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [3:0]  HMASTER;
  logic        sel_a, sel_b;
  logic        load;

  logic [31:0] a_hrdata, a_wdata, a_rdata, b_hrdata, b_wdata, b_rdata;
  logic        a_hready, b_hready, a_en, b_en;
  logic [1:0]  a_hresp, b_hresp;
  logic [13:0] a_addr, b_addr;
  logic [3:0]  a_web, b_web;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_mem_slave #(.DATA_BITS(32), .MEM_ADDR_BITS(14), .RD_LATENCY(1),
                  .WRITE_EN(1'b1), .MASTER_MASK(16'h7FFF)) dut_a (
    .clk(clk), .rst(rst), .HADDR(HADDR), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .HSEL_S(sel_a), .HREADY(a_hready), .HRDATA_S(a_hrdata), .HREADY_S(a_hready),
    .HRESP_S(a_hresp), .mem_enable(a_en), .mem_address(a_addr), .mem_wdata(a_wdata),
    .mem_web(a_web), .mem_rdata(a_rdata));

  ahb_mem_slave #(.DATA_BITS(32), .MEM_ADDR_BITS(14), .RD_LATENCY(3),
                  .WRITE_EN(1'b0), .MASTER_MASK(16'h0004)) dut_b (
    .clk(clk), .rst(rst), .HADDR(HADDR), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .HSEL_S(sel_b), .HREADY(b_hready), .HRDATA_S(b_hrdata), .HREADY_S(b_hready),
    .HRESP_S(b_hresp), .mem_enable(b_en), .mem_address(b_addr), .mem_wdata(b_wdata),
    .mem_web(b_web), .mem_rdata(b_rdata));

  // Memory macro models (256 words each, latency 1 and 3).
  logic [31:0] init_word [256];
  logic [31:0] a_mem [256];
  logic [31:0] b_mem [256];
  logic [31:0] b_p1, b_p2;

  always @(posedge clk) begin
    if (load) begin
      for (int w = 0; w < 256; w++) begin
        a_mem[w] <= init_word[w];
        b_mem[w] <= ~init_word[w];
      end
    end else begin
      if (a_en) begin
        for (int k = 0; k < 4; k++)
          if (a_web[k]) a_mem[a_addr[7:0]][8*k +: 8] <= a_wdata[8*k +: 8];
        if (a_web == 4'b0000) a_rdata <= a_mem[a_addr[7:0]];
      end
      if (b_en) begin
        for (int k = 0; k < 4; k++)
          if (b_web[k]) b_mem[b_addr[7:0]][8*k +: 8] <= b_wdata[8*k +: 8];
      end
      b_p1    <= (b_en && b_web == 4'b0000) ? b_mem[b_addr[7:0]] : 32'hxxxx_xxxx;
      b_p2    <= b_p1;
      b_rdata <= b_p2;
    end
  end

  // Reference: byte-addressed memories and per-instance configuration.
  logic [7:0] ref_mem [0:1][0:1023];
  logic       cur;
  logic [31:0] o_hrdata, o_wdata;
  logic        o_hready, o_en;
  logic [1:0]  o_hresp;
  logic [13:0] o_addr;
  logic [3:0]  o_web;

  assign o_hrdata = cur ? b_hrdata : a_hrdata;
  assign o_wdata  = cur ? b_wdata  : a_wdata;
  assign o_hready = cur ? b_hready : a_hready;
  assign o_en     = cur ? b_en     : a_en;
  assign o_hresp  = cur ? b_hresp  : a_hresp;
  assign o_addr   = cur ? b_addr   : a_addr;
  assign o_web    = cur ? b_web    : a_web;

  function automatic int cfg_lat(input logic which);
    return which ? 3 : 1;
  endfunction
  function automatic bit cfg_we(input logic which);
    return which ? 1'b0 : 1'b1;
  endfunction
  function automatic logic [15:0] cfg_mask(input logic which);
    return which ? 16'h0004 : 16'h7FFF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    sel_a = 1'b0; sel_b = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic drive_addr(input logic which, input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [3:0] mst);
    sel_a = !which; sel_b = which; HTRANS = 2'b10;
    HWRITE = wr; HADDR = addr; HSIZE = size; HMASTER = mst;
  endtask

  // One complete transfer starting with the address phase in the current cycle.
  task automatic xfer(input logic which, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [3:0] mst, input logic [31:0] wdata);
    logic        err;
    logic [3:0]  lanes;
    logic [31:0] exp_rd;
    int          waits;
    int          base;
    logic [15:0] mask;
    cur  = which;
    mask = cfg_mask(which);
    err  = !mask[mst] || (size > 3'd2) || ((addr % (32'd1 << size)) != 0) ||
           (wr && !cfg_we(which));
    lanes = 4'(((1 << (1 << size)) - 1) << addr[1:0]);
    base  = int'(addr[9:2]) * 4;
    drive_addr(which, wr, addr, size, mst);
    step();
    bus_idle();
    HWDATA = wdata;
    #1;
    if (err) begin
      checks++; if (o_hresp !== 2'b01 || o_hready !== 1'b0) begin failures++;
        $display("FAIL err1 addr=%h resp=%b ready=%b exp resp=01 ready=0", addr, o_hresp, o_hready); end
      checks++; if (o_en !== 1'b0 || o_web !== 4'b0000) begin failures++;
        $display("FAIL err1_mem en=%b web=%b exp en=0 web=0000", o_en, o_web); end
      step();
      checks++; if (o_hresp !== 2'b01 || o_hready !== 1'b1 || o_web !== 4'b0000) begin failures++;
        $display("FAIL err2 resp=%b ready=%b web=%b exp resp=01 ready=1 web=0000", o_hresp, o_hready, o_web); end
    end else if (wr) begin
      checks++; if (o_hready !== 1'b1 || o_hresp !== 2'b00 || o_en !== 1'b1) begin failures++;
        $display("FAIL wr_ctl addr=%h ready=%b resp=%b en=%b exp 1/00/1", addr, o_hready, o_hresp, o_en); end
      checks++; if (o_addr !== addr[15:2] || o_web !== lanes || o_wdata !== wdata) begin failures++;
        $display("FAIL wr_mem addr=%h maddr=%h web=%b wdata=%h exp maddr=%h web=%b wdata=%h",
                 addr, o_addr, o_web, o_wdata, addr[15:2], lanes, wdata); end
      for (int k = 0; k < 4; k++)
        if (lanes[k]) ref_mem[which][base + k] = wdata[8*k +: 8];
    end else begin
      exp_rd = {ref_mem[which][base+3], ref_mem[which][base+2],
                ref_mem[which][base+1], ref_mem[which][base]};
      checks++; if (o_en !== 1'b1 || o_web !== 4'b0000 || o_addr !== addr[15:2] || o_hready !== 1'b0) begin failures++;
        $display("FAIL rd_issue addr=%h en=%b web=%b maddr=%h ready=%b exp 1/0000/%h/0",
                 addr, o_en, o_web, o_addr, o_hready, addr[15:2]); end
      waits = 0;
      while (o_hready === 1'b0 && waits < 10) begin
        waits++;
        step();
      end
      checks++; if (waits != cfg_lat(which)) begin failures++;
        $display("FAIL rd_waits addr=%h waits=%0d exp=%0d", addr, waits, cfg_lat(which)); end
      checks++; if (o_hrdata !== exp_rd || o_hresp !== 2'b00) begin failures++;
        $display("FAIL rd_data addr=%h data=%h resp=%b exp data=%h resp=00", addr, o_hrdata, o_hresp, exp_rd); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b1;
    sel_a = 1'b1; sel_b = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
    HADDR = 32'h10; HSIZE = 3'd2; HMASTER = 4'd2; HWDATA = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (a_hready !== 1'b1 || a_hresp !== 2'b00 || a_hrdata !== 32'h0 || a_en !== 1'b0 ||
                    a_web !== 4'h0 || a_addr !== 14'h0 || a_wdata !== 32'h0) begin failures++;
        $display("FAIL reset_a rdy=%b resp=%b rd=%h en=%b web=%b addr=%h wd=%h exp 1/00/0/0/0/0/0",
                 a_hready, a_hresp, a_hrdata, a_en, a_web, a_addr, a_wdata); end
      checks++; if (b_hready !== 1'b1 || b_hresp !== 2'b00 || b_en !== 1'b0 || b_hrdata !== 32'h0) begin failures++;
        $display("FAIL reset_b rdy=%b resp=%b en=%b rd=%h exp 1/00/0/0", b_hready, b_hresp, b_en, b_hrdata); end
    end
    load = 1'b0;
    bus_idle();
    rst = 1'b1;
    step();
    checks++; if (a_hready !== 1'b1 || a_en !== 1'b0 || a_hresp !== 2'b00 || b_en !== 1'b0) begin failures++;
      $display("FAIL post_reset rdy=%b en=%b resp=%b b_en=%b exp 1/0/00/0", a_hready, a_en, a_hresp, b_en); end
  endtask

  task automatic test_word_rw();
    xfer(1'b0, 1'b1, 32'h10, 3'd2, 4'd0, 32'hDEADBEEF);
    xfer(1'b0, 1'b0, 32'h10, 3'd2, 4'd0, 32'h0);
    checks++; if (o_hrdata !== 32'hDEADBEEF) begin failures++;
      $display("FAIL word_rw data=%h exp=deadbeef", o_hrdata); end
  endtask

  task automatic test_byte_lanes();
    xfer(1'b0, 1'b1, 32'h13, 3'd0, 4'd1, 32'hAB00_0000);
    xfer(1'b0, 1'b1, 32'h12, 3'd1, 4'd1, 32'h5A5A_0000);
    xfer(1'b0, 1'b1, 32'h11, 3'd0, 4'd1, 32'h0000_C300);
    xfer(1'b0, 1'b0, 32'h10, 3'd2, 4'd1, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    cur = 1'b0;
    for (int k = 0; k < 3; k++) d[k] = $urandom;
    drive_addr(1'b0, 1'b1, 32'h0, 3'd2, 4'd4);
    step();
    for (int k = 0; k < 3; k++) begin
      HWDATA = d[k];
      if (k < 2) drive_addr(1'b0, 1'b1, 32'(4 * (k + 1)), 3'd2, 4'd4);
      else bus_idle();
      #1;
      checks++; if (a_en !== 1'b1 || a_hready !== 1'b1 || a_addr !== 14'(k) ||
                    a_web !== 4'hF || a_wdata !== d[k]) begin failures++;
        $display("FAIL b2b beat=%0d en=%b rdy=%b addr=%h web=%b wd=%h exp 1/1/%h/1111/%h",
                 k, a_en, a_hready, a_addr, a_web, a_wdata, k, d[k]); end
      for (int j = 0; j < 4; j++) ref_mem[0][4*k + j] = d[k][8*j +: 8];
      step();
    end
    checks++; if (a_en !== 1'b0 || a_hready !== 1'b1) begin failures++;
      $display("FAIL b2b_end en=%b rdy=%b exp 0/1", a_en, a_hready); end
    for (int k = 0; k < 3; k++) xfer(1'b0, 1'b0, 32'(4 * k), 3'd2, 4'd4, 32'h0);
  endtask

  task automatic test_errors();
    xfer(1'b1, 1'b1, 32'h20, 3'd2, 4'd2, 32'h1234_5678);   // read-only instance
    xfer(1'b1, 1'b0, 32'h40, 3'd2, 4'd3, 32'h0);           // master 3 filtered
    xfer(1'b1, 1'b0, 32'h40, 3'd2, 4'd2, 32'h0);           // captured during ERR2
    xfer(1'b0, 1'b0, 32'h22, 3'd2, 4'd0, 32'h0);           // misaligned word
    xfer(1'b0, 1'b1, 32'h24, 3'd3, 4'd0, 32'h0);           // oversize
    xfer(1'b0, 1'b1, 32'h24, 3'd2, 4'd15, 32'h0);          // master 15 filtered
  endtask

  task automatic test_no_capture();
    cur = 1'b0;
    step();
    sel_a = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h8; HSIZE = 3'd2; HMASTER = 4'd0;
    step();
    checks++; if (a_en !== 1'b0 || a_hready !== 1'b1 || a_hresp !== 2'b00) begin failures++;
      $display("FAIL busy_nocap en=%b rdy=%b resp=%b exp 0/1/00", a_en, a_hready, a_hresp); end
    sel_a = 1'b0; HTRANS = 2'b10;
    step();
    checks++; if (a_en !== 1'b0 || a_web !== 4'h0) begin failures++;
      $display("FAIL nosel_nocap en=%b web=%b exp 0/0000", a_en, a_web); end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    cur = 1'b1;
    drive_addr(1'b1, 1'b0, 32'h44, 3'd2, 4'd2);
    step();
    bus_idle();
    step();
    rst = 1'b0;
    #1;
    checks++; if (b_hready !== 1'b1 || b_hrdata !== 32'h0 || b_en !== 1'b0 || b_hresp !== 2'b00) begin failures++;
      $display("FAIL rst_rd rdy=%b rd=%h en=%b resp=%b exp 1/0/0/00", b_hready, b_hrdata, b_en, b_hresp); end
    step();
    rst = 1'b1;
    cur = 1'b0;
    drive_addr(1'b0, 1'b1, 32'h30, 3'd2, 4'd0);
    step();
    bus_idle();
    HWDATA = 32'hBAD0_BAD0;
    rst = 1'b0;
    #1;
    checks++; if (a_web !== 4'h0 || a_en !== 1'b0) begin failures++;
      $display("FAIL rst_wr web=%b en=%b exp 0000/0", a_web, a_en); end
    step();
    rst = 1'b1;
    step();
    xfer(1'b0, 1'b0, 32'h30, 3'd2, 4'd0, 32'h0);
  endtask

  task automatic test_random();
    logic        which, wr;
    logic [2:0]  size;
    logic [3:0]  mst;
    logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      which = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      size  = 3'($urandom_range(0, 3));
      mst   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
      addr  = 32'($urandom_range(0, 255) * 4);
      if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (size < 3'd2) addr = addr + 32'(($urandom_range(0, 3) >> size) << size);
      xfer(which, wr, addr, size, mst, $urandom);
    end
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    cur = 1'b0; HMASTLOCK = 1'b0; load = 1'b0;
    bus_idle();
    for (int w = 0; w < 256; w++) begin
      init_word[w] = $urandom;
      for (int k = 0; k < 4; k++) begin
        ref_mem[0][4*w + k] = init_word[w][8*k +: 8];
        ref_mem[1][4*w + k] = ~init_word[w][8*k +: 8];
      end
    end
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_back_to_back();
    test_errors();
    test_no_capture();
    test_reset_mid();
    test_random();
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
